// File: rtl/issue_hazard_controller.sv
// Issue scoreboard: timing wheel of in-flight register writes, hazard stalls, wb strobe.
// Optional ISSUE_FORWARD_EN: a reader may issue in the cycle its source retires.
module issue_hazard_controller #(
  parameter int NREG    = 16,
  parameter int LAT_IMM = 1,
  parameter int LAT_ALU = 2,
  parameter int LAT_MEM = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dec_valid,
  input  logic [$clog2(NREG)-1:0]      dec_rs1,
  input  logic [$clog2(NREG)-1:0]      dec_rs2,
  input  logic                         dec_rs1_used,
  input  logic                         dec_rs2_used,
  input  logic [$clog2(NREG)-1:0]      dec_rd,
  input  logic                         dec_reg_we,
  input  logic [1:0]                   dec_write_from,
  input  logic                         dec_mem_write,
  output logic                         issue_ready,
  output logic                         wb_valid,
  output logic [$clog2(NREG)-1:0]      wb_reg,
  output logic [1:0]                   wb_from,
  output logic [NREG-1:0]              busy_mask,
  output logic [$clog2(LAT_MEM+1)-1:0] loads_inflight
);

  localparam int RW = $clog2(NREG);
  localparam int LW = $clog2(LAT_MEM+1);

  logic          w_v [LAT_MEM];
  logic [RW-1:0] w_r [LAT_MEM];
  logic [1:0]    w_f [LAT_MEM];
  logic          n_v [LAT_MEM];
  logic [RW-1:0] n_r [LAT_MEM];
  logic [1:0]    n_f [LAT_MEM];

  logic [NREG-1:0] n_mask;
  logic [LW-1:0]   n_cnt;

  int   lat;
  logic raw1, raw2, raw, waw, port, order;
  logic issue;

  function automatic int lat_of(input logic [1:0] f);
    case (f)
      2'b00:   return LAT_MEM;
      2'b10:   return LAT_IMM;
      default: return LAT_ALU;
    endcase
  endfunction

  // Slot 0 is the write retiring this cycle.
  assign wb_valid = w_v[0];
  assign wb_reg   = w_r[0];
  assign wb_from  = w_f[0];

  // Hazard detection against the current wheel contents.
  always_comb begin
    lat  = lat_of(dec_write_from);
    raw1 = dec_rs1_used && busy_mask[dec_rs1];
    raw2 = dec_rs2_used && busy_mask[dec_rs2];
`ifdef ISSUE_FORWARD_EN
    if (wb_valid && wb_reg == dec_rs1) raw1 = 1'b0;
    if (wb_valid && wb_reg == dec_rs2) raw2 = 1'b0;
`endif
    raw   = (dec_reg_we || dec_mem_write) && (raw1 || raw2);
    waw   = dec_reg_we && busy_mask[dec_rd]
            && !(wb_valid && wb_reg == dec_rd);
    // Slot lat-1 after the shift holds what is in slot lat now.
    port  = 1'b0;
    for (int j = 1; j < LAT_MEM; j++) begin
      if (dec_reg_we && j == lat && w_v[j]) port = 1'b1;
    end
    order = dec_mem_write && (loads_inflight != '0);
    issue_ready = !dec_valid || !(raw || waw || port || order);
    issue = dec_valid && issue_ready && dec_reg_we;
  end

  // Next wheel: shift toward slot 0, then drop the new write into its slot.
  always_comb begin
    for (int j = 0; j < LAT_MEM - 1; j++) begin
      n_v[j] = w_v[j+1];
      n_r[j] = w_r[j+1];
      n_f[j] = w_f[j+1];
    end
    n_v[LAT_MEM-1] = 1'b0;
    n_r[LAT_MEM-1] = '0;
    n_f[LAT_MEM-1] = '0;
    if (issue) begin
      for (int j = 0; j < LAT_MEM; j++) begin
        if (j == lat - 1) begin
          n_v[j] = 1'b1;
          n_r[j] = dec_rd;
          n_f[j] = dec_write_from;
        end
      end
    end
    n_mask = '0;
    n_cnt  = '0;
    for (int j = 0; j < LAT_MEM; j++) begin
      if (n_v[j]) begin
        n_mask[n_r[j]] = 1'b1;
        if (n_f[j] == 2'b00) n_cnt = n_cnt + LW'(1);
      end
    end
  end

  // Wheel, busy mask and load count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < LAT_MEM; j++) begin
        w_v[j] <= 1'b0;
        w_r[j] <= '0;
        w_f[j] <= '0;
      end
      busy_mask      <= '0;
      loads_inflight <= '0;
    end else begin
      for (int j = 0; j < LAT_MEM; j++) begin
        w_v[j] <= n_v[j];
        w_r[j] <= n_r[j];
        w_f[j] <= n_f[j];
      end
      busy_mask      <= n_mask;
      loads_inflight <= n_cnt;
    end
  end

endmodule
